// File: rtl/rice_partition_sequencer.sv
// Ping-pong residual buffer that picks a Rice parameter per partition and replays it to the encoder.
// Build option RICE2_EN raises the parameter ceiling from 14 to 30 (oRiceParam stays 5 bits).
`timescale 1ns/1ps

// state     | meaning
// S_IDLE    | waiting for the drain bank to be marked full
// S_CALC    | one parameter candidate tested per cycle
// S_ANNOUNCE| change-param pulse, first read issued
// S_STREAM  | one sample per cycle to the encoder
// S_FLUSH   | flush pulse after the last partition of a block
module rice_partition_sequencer #(
  parameter int PARTITION_SIZE = 256,
  parameter int CNT_W          = 9,
  parameter int SUM_W          = 24
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iEnable,
  input  logic        iValid,
  input  logic [15:0] iResidual,
  input  logic        iLast,
  output logic        oReady,
  output logic        oEncValid,
  output logic [15:0] oEncSample,
  output logic [4:0]  oRiceParam,
  output logic        oChangeParam,
  output logic        oFlush,
  output logic        oBusy
);
  localparam int AW = $clog2(PARTITION_SIZE);
  localparam int CW = SUM_W + 5;
`ifdef RICE2_EN
  localparam logic [4:0] KMAX = 5'd30;
`else
  localparam logic [4:0] KMAX = 5'd14;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_ANNOUNCE,
    S_STREAM,
    S_FLUSH
  } state_t;

  state_t           r_state;
  logic             r_fill_bank;
  logic             r_drain_bank;
  logic [CNT_W-1:0] r_cnt [2];
  logic [SUM_W-1:0] r_sum [2];
  logic [1:0]       r_full;
  logic [1:0]       r_last;
  logic [4:0]       r_k;
  logic [CNT_W-1:0] r_idx;
  logic             r_ready;
  logic             r_enc_valid;
  logic             r_change;
  logic             r_flush;
  logic [4:0]       r_rice_param;
  logic [15:0]      r_rd_data;
  logic [15:0]      r_mem0 [PARTITION_SIZE];
  logic [15:0]      r_mem1 [PARTITION_SIZE];

  logic             w_accept;
  logic             w_close;
  logic             w_free;
  logic             w_stream_end;
  logic             w_k_step;
  logic             w_fill_nxt;
  logic [1:0]       w_full_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [15:0]      w_zz;
  logic [AW-1:0]    w_wr_addr;
  logic [AW-1:0]    w_rd_addr;
  logic [5:0]       w_shamt;
  logic [CW-1:0]    w_shifted;
  logic [CW-1:0]    w_sum_ext;

  assign w_accept  = iValid & r_ready & iEnable;
  assign w_cnt_inc = r_cnt[r_fill_bank] + CNT_W'(1);
  assign w_close   = w_accept & ((w_cnt_inc == CNT_W'(PARTITION_SIZE)) | iLast);
  assign w_wr_addr = r_cnt[r_fill_bank][AW-1:0];

  // Zig-zag: negatives map to 2*~r+1, so -32768 lands on 65535 without overflow.
  assign w_zz = iResidual[15] ? {~iResidual[14:0], 1'b1} : {iResidual[14:0], 1'b0};

  assign w_stream_end = (r_state == S_STREAM) && (r_idx == r_cnt[r_drain_bank] - CNT_W'(1));
  assign w_free       = (w_stream_end && !r_last[r_drain_bank]) || (r_state == S_FLUSH);
  assign w_rd_addr    = (r_state == S_STREAM) ? r_idx[AW-1:0] + AW'(1) : '0;

  assign w_shamt   = {1'b0, r_k} + 6'd1;
  assign w_shifted = CW'(r_cnt[r_drain_bank]) << w_shamt;
  assign w_sum_ext = CW'(r_sum[r_drain_bank]);
  assign w_k_step  = (w_shifted <= w_sum_ext) && (r_k < KMAX);

  // Fill and drain always touch opposite banks, so both updates can land in one cycle.
  always_comb begin
    w_full_nxt = r_full;
    if (w_close) w_full_nxt[r_fill_bank] = 1'b1;
    if (w_free)  w_full_nxt[r_drain_bank] = 1'b0;
  end
  assign w_fill_nxt = w_close ? ~r_fill_bank : r_fill_bank;

  always_ff @(posedge iClock) begin
    if (iEnable) begin
      if (w_accept) begin
        if (r_fill_bank) r_mem1[w_wr_addr] <= iResidual;
        else             r_mem0[w_wr_addr] <= iResidual;
      end
      r_rd_data <= r_drain_bank ? r_mem1[w_rd_addr] : r_mem0[w_rd_addr];
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_state      <= S_IDLE;
      r_fill_bank  <= 1'b0;
      r_drain_bank <= 1'b0;
      r_cnt[0]     <= '0;
      r_cnt[1]     <= '0;
      r_sum[0]     <= '0;
      r_sum[1]     <= '0;
      r_full       <= '0;
      r_last       <= '0;
      r_k          <= '0;
      r_idx        <= '0;
      r_ready      <= 1'b0;
      r_enc_valid  <= 1'b0;
      r_change     <= 1'b0;
      r_flush      <= 1'b0;
      r_rice_param <= '0;
    end else if (iEnable) begin
      r_full      <= w_full_nxt;
      r_fill_bank <= w_fill_nxt;
      r_ready     <= ~w_full_nxt[w_fill_nxt];
      r_change    <= 1'b0;
      r_flush     <= 1'b0;

      if (w_accept) begin
        r_cnt[r_fill_bank] <= w_cnt_inc;
        r_sum[r_fill_bank] <= r_sum[r_fill_bank] + {{(SUM_W-16){1'b0}}, w_zz};
        if (w_close) r_last[r_fill_bank] <= iLast;
      end

      if (w_free) begin
        r_cnt[r_drain_bank]  <= '0;
        r_sum[r_drain_bank]  <= '0;
        r_last[r_drain_bank] <= 1'b0;
        r_drain_bank         <= ~r_drain_bank;
      end

      case (r_state)
        S_IDLE: begin
          if (r_full[r_drain_bank]) begin
            r_k     <= '0;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          if (w_k_step) begin
            r_k <= r_k + 5'd1;
          end else begin
            r_rice_param <= r_k;
            r_change     <= 1'b1;
            r_state      <= S_ANNOUNCE;
          end
        end
        S_ANNOUNCE: begin
          r_enc_valid <= 1'b1;
          r_idx       <= '0;
          r_state     <= S_STREAM;
        end
        S_STREAM: begin
          if (w_stream_end) begin
            r_enc_valid <= 1'b0;
            r_flush     <= r_last[r_drain_bank];
            r_state     <= r_last[r_drain_bank] ? S_FLUSH : S_IDLE;
          end else begin
            r_idx <= r_idx + CNT_W'(1);
          end
        end
        S_FLUSH: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign oReady       = r_ready;
  assign oEncValid    = r_enc_valid & iEnable;
  assign oEncSample   = oEncValid ? r_rd_data : '0;
  assign oRiceParam   = r_rice_param;
  assign oChangeParam = r_change & iEnable;
  assign oFlush       = r_flush & iEnable;
  assign oBusy        = r_full[0] | r_full[1] | (r_cnt[r_fill_bank] != '0) | (r_state != S_IDLE);

endmodule

// File: tb/tb_rice_partition_sequencer.sv
// Self-checking bench for rice_partition_sequencer: partition-level reference model plus directed cases.
`timescale 1ns/1ps

module tb_rice_partition_sequencer;
  localparam int PS = 256;
`ifdef RICE2_EN
  localparam int KMAX  = 30;
  localparam int BIG_K = 15;
`else
  localparam int KMAX  = 14;
  localparam int BIG_K = 14;
`endif

  logic        iClock = 1'b0;
  logic        iReset = 1'b1;
  logic        iEnable = 1'b0;
  logic        iValid = 1'b0;
  logic [15:0] iResidual = '0;
  logic        iLast = 1'b0;
  logic        oReady, oEncValid, oChangeParam, oFlush, oBusy;
  logic [15:0] oEncSample;
  logic [4:0]  oRiceParam;

  rice_partition_sequencer dut (
    .iClock(iClock), .iReset(iReset), .iEnable(iEnable), .iValid(iValid),
    .iResidual(iResidual), .iLast(iLast), .oReady(oReady), .oEncValid(oEncValid),
    .oEncSample(oEncSample), .oRiceParam(oRiceParam), .oChangeParam(oChangeParam),
    .oFlush(oFlush), .oBusy(oBusy)
  );

  always #5 iClock = ~iClock;

  typedef struct {
    int     cnt;
    longint sum;
    bit     last;
    int     close_cyc;
  } part_t;

  part_t                pq[$];
  logic signed [15:0]   sq[$];
  int checks = 0, errors = 0;
  int cyc = 0, held = 0, cur_cnt = 0, remaining = 0, stream_len = 0;
  longint cur_sum = 0;
  bit primed = 0, post_reset = 0, in_drain = 0, cur_last = 0, flush_due = 0, rand_en = 0;
  int exp_param = 0, last_param = -1, last_gap = -1, last_len = -1;
  int change_cnt = 0, flush_cnt = 0, ready_low = 0;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic longint zz(input logic signed [15:0] r);
    return (r >= 0) ? 2 * longint'(r) : -2 * longint'(r) - 1;
  endfunction

  // Largest k allowed such that the partition's mean magnitude still reaches 2^k.
  function automatic int kcalc(input int cnt, input longint sum);
    int k = 0;
    while (k < KMAX && (longint'(cnt) * (longint'(1) << (k + 1))) <= sum) k++;
    return k;
  endfunction

  always @(negedge iClock) begin
    part_t p;
    logic signed [15:0] s;
    cyc++;
    if (iReset) begin
      pq.delete(); sq.delete();
      held = 0; primed = 0; cur_cnt = 0; cur_sum = 0;
      in_drain = 0; remaining = 0; flush_due = 0; post_reset = 1;
    end else begin
      if (post_reset) begin
        chk("rst_valid", oEncValid, 0);
        chk("rst_change", oChangeParam, 0);
        chk("rst_flush", oFlush, 0);
        chk("rst_param", oRiceParam, 0);
        chk("rst_ready", oReady, 0);
        chk("rst_busy", oBusy, 0);
        post_reset = 0;
      end
      if (!iEnable) begin
        chk("hold_valid", oEncValid, 0);
        chk("hold_change", oChangeParam, 0);
        chk("hold_flush", oFlush, 0);
      end else begin
        chk("ready", oReady, (primed && held < 2));
        chk("busy", oBusy, (held > 0 || cur_cnt > 0));
        chk("flush", oFlush, flush_due);
        if (flush_due) begin
          flush_cnt++; held--; flush_due = 0;
        end
        if (oChangeParam) begin
          change_cnt++;
          chk("change_alone", oEncValid, 0);
          if (in_drain || pq.size() == 0) begin
            checks++; errors++;
            $display("FAIL change_unexpected: actual pulse required none (queued %0d, cycle %0d)", pq.size(), cyc);
          end else begin
            p = pq.pop_front();
            exp_param = kcalc(p.cnt, p.sum);
            chk("rice_param", oRiceParam, exp_param);
            remaining = p.cnt; cur_last = p.last; in_drain = 1;
            last_gap = cyc - p.close_cyc; last_param = int'(oRiceParam); stream_len = 0;
          end
        end else if (oEncValid) begin
          if (!in_drain || sq.size() == 0) begin
            checks++; errors++;
            $display("FAIL valid_unexpected: actual valid required idle (cycle %0d)", cyc);
          end else begin
            s = sq.pop_front();
            chk("sample", $signed(oEncSample), s);
            chk("param_stable", oRiceParam, exp_param);
            remaining--; stream_len++;
            if (remaining == 0) begin
              in_drain = 0; last_len = stream_len;
              if (cur_last) flush_due = 1;
              else held--;
            end
          end
        end else if (in_drain) begin
          checks++; errors++;
          $display("FAIL stream_gap: actual valid 0 required 1 (%0d left, cycle %0d)", remaining, cyc);
          in_drain = 0;
        end
        if (iValid && oReady) begin
          sq.push_back($signed(iResidual));
          cur_cnt++; cur_sum += zz($signed(iResidual));
          if (cur_cnt == PS || iLast) begin
            p.cnt = cur_cnt; p.sum = cur_sum; p.last = iLast; p.close_cyc = cyc;
            pq.push_back(p);
            held++; cur_cnt = 0; cur_sum = 0;
          end
        end
        if (iValid && !oReady) ready_low++;
        primed = 1;
      end
    end
  end

  task automatic send(input logic [15:0] r, input bit last);
    bit ok = 0;
    iValid = 1'b1; iResidual = r; iLast = last;
    for (int t = 0; t < 5000 && !ok; t++) begin
      @(negedge iClock);
      ok = oReady && iEnable;
      @(posedge iClock); #1;
      if (rand_en) iEnable = ($urandom_range(0, 7) != 0);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: actual not accepted required accepted (cycle %0d)", cyc);
    end
    iLast = 1'b0;
  endtask

  task automatic idle(input int n);
    iValid = 1'b0;
    repeat (n) begin @(posedge iClock); #1; end
  endtask

  task automatic wait_idle();
    bit done = 0;
    iValid = 1'b0; iEnable = 1'b1;
    for (int t = 0; t < 20000 && !done; t++) begin
      @(negedge iClock);
      done = !oBusy && !in_drain && !flush_due;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL idle_timeout: actual busy required idle (cycle %0d)", cyc);
    end
    @(posedge iClock); #1;
  endtask

  task automatic pulse_reset();
    @(posedge iClock); #1; iReset = 1'b1; iValid = 1'b0;
    @(posedge iClock); #1; iReset = 1'b0;
  endtask

  initial begin
    int bc, bf, rng, v;
    bit found;
    repeat (3) @(posedge iClock);
    #1; iReset = 1'b0; iEnable = 1'b1;
    idle(2);

    bc = change_cnt; bf = flush_cnt;
    for (int i = 0; i < PS; i++) send(16'd0, 0);
    wait_idle();
    chk("zeros_param", last_param, 0);
    chk("zeros_gap", last_gap, 3);
    chk("zeros_len", last_len, 256);
    chk("zeros_changes", change_cnt - bc, 1);
    chk("zeros_flushes", flush_cnt - bf, 0);

    for (int i = 0; i < PS; i++) send(16'd100, 0);
    wait_idle();
    chk("p100_param", last_param, 7);
    chk("p100_gap", last_gap, 10);
    chk("p100_len", last_len, 256);

    bf = flush_cnt;
    for (int i = 0; i < 10; i++) send(16'hFFFF, i == 9);
    wait_idle();
    chk("m1_param", last_param, 0);
    chk("m1_len", last_len, 10);
    chk("m1_flushes", flush_cnt - bf, 1);

    for (int i = 0; i < PS; i++) send(16'h8000, 0);
    wait_idle();
    chk("min_param", last_param, BIG_K);
    chk("min_gap", last_gap, BIG_K + 3);

    bc = change_cnt; ready_low = 0;
    for (int i = 0; i < 3 * PS; i++) send(16'((i % 4) - 1), 0);
    wait_idle();
    chk("pp_ready_low", ready_low, 3);
    chk("pp_changes", change_cnt - bc, 3);

    for (int i = 0; i < PS; i++) send(16'd0, 0);
    idle(1);
    found = 0;
    for (int t = 0; t < 2000 && !found; t++) begin
      @(negedge iClock);
      found = in_drain && stream_len >= 40;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL rst_wait: actual no stream required stream (cycle %0d)", cyc);
    end
    pulse_reset();
    idle(2);
    bf = flush_cnt;
    for (int i = 0; i < 16; i++) send((i % 2) ? 16'hFFFC : 16'd3, i == 15);
    wait_idle();
    chk("rst_blk_len", last_len, 16);
    chk("rst_blk_param", last_param, 2);
    chk("rst_blk_flushes", flush_cnt - bf, 1);

    rand_en = 1;
    rng = 3;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 4));
      if ($urandom_range(0, 63) == 0) rng = (i % 4 == 0) ? 3 : (i % 4 == 1) ? 100 : (i % 4 == 2) ? 3000 : 32767;
      v = $urandom_range(0, 2 * rng) - rng;
      if (rng == 32767 && $urandom_range(0, 15) == 0) v = -32768;
      send(16'(v), (i == 2499) || ($urandom_range(0, 99) == 0));
    end
    rand_en = 0;
    wait_idle();
    chk("rand_drained", sq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
